// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer. A radix-2
//                shift-add (multiply) / restoring shift-subtract (divide)
//                engine driven by a four-state FSM. Operands are reduced to
//                magnitudes on acceptance and the sign is restored at the
//                end, so the datapath itself is purely unsigned.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous active-high reset
//                start    - request strobe, honoured only in IDLE
//                op[2:0]  - RV32M funct3 (MUL..REMU)
//                rs1_val  - dividend / multiplicand
//                rs2_val  - divisor / multiplier
//                kill     - pipeline flush, aborts any operation in flight
//                busy     - high from acceptance through the done cycle
//                done     - one-cycle completion pulse
//                result   - registered result, held until the next done
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ALL_ONES = {XLEN{1'b1}};

    // funct3 encodings
    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_REM    = 3'd6;

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic               r_neg;
    // r_hi: product high word (multiply) or partial remainder R (divide).
    // R is always below the divisor, so its 33rd bit only ever exists in the
    // shifted trial value and never needs to be stored.
    logic [XLEN-1:0]    r_hi;
    // r_lo: multiplier / product low word (multiply) or quotient Q (divide)
    logic [XLEN-1:0]    r_lo;
    // r_opnd: multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [XLEN-1:0]    r_opnd;

    // ------------------------------------------------------------------
    // Acceptance-time decode
    // ------------------------------------------------------------------
    logic            w_sgn1;
    logic            w_sgn2;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_neg;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;

    assign w_sgn1 = (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                    (op == c_OP_DIV)  || (op == c_OP_REM);
    assign w_sgn2 = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);

    assign w_neg1 = w_sgn1 & rs1_val[XLEN-1];
    assign w_neg2 = w_sgn2 & rs2_val[XLEN-1];

    assign w_mag1 = w_neg1 ? (~rs1_val + 1'b1) : rs1_val;
    assign w_mag2 = w_neg2 ? (~rs2_val + 1'b1) : rs2_val;

    // A remainder takes the sign of the dividend only
    assign w_neg = (op == c_OP_REM) ? w_neg1 : (w_neg1 ^ w_neg2);

    assign w_div_zero = op[2] && (rs2_val == '0);
    assign w_div_ovf  = ((op == c_OP_DIV) || (op == c_OP_REM)) &&
                        (rs1_val == c_INT_MIN) && (rs2_val == c_ALL_ONES);
    assign w_special  = w_div_zero || w_div_ovf;

    // op[1] distinguishes REM* from DIV*
    always_comb begin
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = op[1] ? rs1_val : c_ALL_ONES;
        end else begin
            w_special_val = op[1] ? '0 : c_INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_rsh;
    logic [XLEN+1:0] w_div_trial;
    logic            w_div_ge;

    // Carry of the add lands in bit XLEN and is shifted back into hi
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_rsh   = {r_hi, r_lo[XLEN-1]};
    assign w_div_trial = {1'b0, w_div_rsh} - {2'b00, r_opnd};
    assign w_div_ge    = ~w_div_trial[XLEN+1];

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_div_mag;
    logic [XLEN-1:0]   w_div_s;
    logic [XLEN-1:0]   w_fix_val;

    // MULH/MULHSU must negate the full 64-bit product before taking the
    // upper half, otherwise the borrow from the low word is lost.
    assign w_prod    = {r_hi, r_lo};
    assign w_prod_s  = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_div_mag = r_op[1] ? r_hi : r_lo;
    assign w_div_s   = r_neg ? (~w_div_mag + 1'b1) : w_div_mag;

    always_comb begin
        w_fix_val = '0;
        if (r_op[2]) begin
            w_fix_val = w_div_s;
        end else if (r_op == c_OP_MUL) begin
            w_fix_val = w_prod_s[XLEN-1:0];
        end else begin
            w_fix_val = w_prod_s[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else if (kill) begin
            // Abort: result deliberately left untouched
            r_state <= c_ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_op  <= op;
                        r_neg <= w_neg;
                        busy  <= 1'b1;
                        if (w_special) begin
                            result  <= w_special_val;
                            done    <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= op[2] ? w_mag1 : w_mag2;
                            r_opnd  <= op[2] ? w_mag2 : w_mag1;
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= c_ST_CALC;
                        end
                    end
                end

                c_ST_CALC: begin
                    if (r_op[2]) begin
                        r_hi <= w_div_ge ? w_div_trial[XLEN-1:0] : w_div_rsh[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= c_ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                c_ST_FIX: begin
                    result  <= w_fix_val;
                    done    <= 1'b1;
                    r_state <= c_ST_DONE;
                end

                c_ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It replaces the single-cycle combinational multiply and divide paths in the execute-stage ALU with an iterative radix-2 shift-add/shift-subtract engine and a small FSM. The core stalls on `busy` and collects the result on `done`. All non-M instructions stay in the combinational ALU.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`, in, 1: system clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request strobe. Sampled only in IDLE.
- `op`, in, 3: operation, encoded as RV32M funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val`, in, 32: dividend / multiplicand. Captured on the accepted `start`.
- `rs2_val`, in, 32: divisor / multiplier. Captured on the accepted `start`.
- `kill`, in, 1: pipeline flush. Aborts any operation in flight.
- `busy`, out, 1: high from the cycle after acceptance until `done` deasserts.
- `done`, out, 1: one-cycle pulse. `result` is valid in this cycle.
- `result`, out, 32: registered result. Holds its value until the next `done`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start=1` and `kill=0`: latch `op` and operands, then decode signedness.
  - Signed operands: rs1 for MULH/MULHSU/DIV/REM; rs2 for MULH/DIV/REM. Store their magnitudes and `neg = sign1 ^ sign2`. For REM, `neg = sign1` only.
  - Div special cases go IDLE→DONE directly:
    - rs2==0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1.
    - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV = 0x80000000, REM = 0.
  - All other cases: load `cnt=31` and go to CALC.
- **CALC, multiply**: 64-bit accumulator {hi, lo}, lo initialised to |rs2|, hi to 0.
  - Each cycle: if lo[0], hi += |rs1| (33-bit sum, carry kept).
  - Then shift {carry, hi, lo} right by 1.
- **CALC, divide**: remainder R (33 bits, starts at 0), quotient Q initialised to |rs1|.
  - Each cycle: {R, Q} <<= 1; trial = R − |rs2|.
  - If trial ≥ 0: R = trial and Q[0] = 1.
- `cnt` decrements each CALC cycle. When `cnt==0`, go to FIX.
- **FIX**: take the magnitude result (lo for MUL, hi for MULH*, Q for DIV*, R for REM*).
  - If `neg`, apply two's complement. For MULH/MULHSU the negation is over the full 64 bits, then the upper half is taken.
  - Load `result` and go to DONE.
- **DONE**: `done=1` for this cycle only; next state IDLE.
- `start` outside IDLE is ignored; there is no queue.
- `kill` in any state: next state IDLE, `done` is not raised, and `result` is unchanged. `kill` in the same cycle as `start` in IDLE means nothing is accepted.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `result=0`, `cnt=0`.
- `rst` overrides both `kill` and `start`. Reset in mid-operation returns to IDLE on the next edge with no `done`.
- Let edge E0 be the edge that accepts `start`.
- Normal latency:
  - CALC occupies E1..E32.
  - FIX at E33.
  - `done`/`result` visible in the cycle after E33, i.e. 34 cycles from the `start` cycle.
- Special-case latency: `done` is visible in the cycle after E0 (1 cycle).
- `busy`: high after E0 through the `done` cycle inclusive; low in IDLE.
- Back-to-back: a new `start` is accepted the cycle after `done`, so the minimum issue interval is 35 cycles (normal) or 2 cycles (special).
- Operand inputs may change freely after E0.

## Test plan
- **MUL/MULH**: MUL 0x00010000 × 0x00010000 → `result` 0x00000000. Same operands as MULHU → 0x00000001. `done` exactly 34 cycles after `start`.
- **Signed mixes**: MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- **Division signs**: DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC. REMU 7 / 0xFFFFFFFF → 7.
- **Special cases**: DIV 5 / 0 → 0xFFFFFFFF. REMU 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000. REM same operands → 0. Each completes with `done` 1 cycle after `start`.
- **kill**: `kill` at CALC cycle 10 → IDLE next cycle, `busy=0`, no `done`, `result` keeps its prior value. A following `start` completes normally.
- **rst / start while busy**: `start` pulses during CALC are ignored, and the original operation's result is returned. `rst` in FIX → all outputs at reset values next cycle, no `done`. Random 10k-op run matches a reference model.
